dbg_mem_bridge: RTL and testbench

- Host-side debug responder for the pipelined MIPS data memory; replaces hierarchical pokes and peeks into Data_MEM with a real port.
- Accepts word read and write requests from a host (bench or external controller) over a req/ack handshake.
- Freezes the CPU pipeline through a stall line and takes over the data-memory port for the access.
- Sits beside the data memory. A mux in the MIPS top selects between the CPU MEM stage and this block while `mem_sel` is high.

---
 rtl/dbg_mem_bridge.sv | 125 ++++++++++++
 tb/tb_dbg_mem_bridge.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/dbg_mem_bridge.sv
// Host debug port into the MIPS data memory: freezes the pipeline, borrows
// the memory port for one word read or write, then hands it back.
module dbg_mem_bridge #(
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 64,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic              dbg_err,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              cpu_stall,
  input  logic              cpu_mem_busy,
  output logic              mem_sel,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, STALL, ACCESS, RDCAP, DONE, WAITLOW} state_t;

  localparam logic [ADDR_W:0] DEPTH = MEM_DEPTH[ADDR_W:0];

  state_t              state_q, state_d;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                in_range;

  logic                ack_d, err_d, stall_d, sel_d, en_d, mwe_d;
  logic [ADDR_W-1:0]   maddr_d;
  logic [DATA_W-1:0]   mwdata_d, rdata_d;
  logic                ack_q, err_q, stall_q, sel_q, en_q, mwe_q;
  logic [ADDR_W-1:0]   maddr_q;
  logic [DATA_W-1:0]   mwdata_q, rdata_q;

  assign in_range = ({1'b0, dbg_addr} < DEPTH);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (dbg_req) state_d = in_range ? STALL : DONE;
      STALL:   if (!cpu_mem_busy) state_d = ACCESS;
      ACCESS:  state_d = we_q ? DONE : RDCAP;
      RDCAP:   state_d = DONE;
      DONE:    state_d = WAITLOW;
      WAITLOW: if (!dbg_req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so each one is a flop that
  // lines up exactly with the state it belongs to.
  always_comb begin
    stall_d  = (state_d == STALL) || (state_d == ACCESS) || (state_d == RDCAP);
    sel_d    = (state_d == ACCESS) || (state_d == RDCAP);
    en_d     = (state_d == ACCESS);
    mwe_d    = en_d && we_q;
    maddr_d  = en_d ? addr_q : '0;
    mwdata_d = mwe_d ? wdata_q : '0;
    ack_d    = (state_d == DONE);
    // The only way to reach DONE straight from IDLE is an out-of-range address.
    err_d    = ack_d && (state_q == IDLE);
    rdata_d  = (state_q == RDCAP) ? mem_rdata : rdata_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (state_q == IDLE && dbg_req) begin
      we_q    <= dbg_we;
      addr_q  <= dbg_addr;
      wdata_q <= dbg_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      stall_q  <= 1'b0;
      sel_q    <= 1'b0;
      en_q     <= 1'b0;
      mwe_q    <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      rdata_q  <= '0;
    end else begin
      ack_q    <= ack_d;
      err_q    <= err_d;
      stall_q  <= stall_d;
      sel_q    <= sel_d;
      en_q     <= en_d;
      mwe_q    <= mwe_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      rdata_q  <= rdata_d;
    end
  end

  assign dbg_ack   = ack_q;
  assign dbg_err   = err_q;
  assign dbg_rdata = rdata_q;
  assign cpu_stall = stall_q;
  assign mem_sel   = sel_q;
  assign mem_en    = en_q;
  assign mem_we    = mwe_q;
  assign mem_addr  = maddr_q;
  assign mem_wdata = mwdata_q;

endmodule

// File: tb/tb_dbg_mem_bridge.sv
// Scoreboard bench for dbg_mem_bridge: a driver queues expected responses,
// a negedge monitor checks every ack against them plus per-access side effects.
module tb_dbg_mem_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        dbg_req, dbg_we;
  logic [7:0]  dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_ack, dbg_err;
  logic [31:0] dbg_rdata;
  logic        cpu_stall, cpu_mem_busy;
  logic        mem_sel, mem_en, mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  dbg_mem_bridge #(.ADDR_W(8), .MEM_DEPTH(64), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_err(dbg_err), .dbg_rdata(dbg_rdata),
    .cpu_stall(cpu_stall), .cpu_mem_busy(cpu_mem_busy),
    .mem_sel(mem_sel), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous data memory, one cycle read latency.
  logic [31:0] ram [0:255];
  initial for (int i = 0; i < 256; i++) ram[i] = 32'h1000 + i;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          ack_cyc;
    int          stall;
    int          en;
    int          sel;
    logic        we;
    logic [7:0]  addr;
  } exp_t;

  exp_t exp_q[$];
  int   nvec = 0;
  int   nfail = 0;
  int   acks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: accumulate side effects between acks, compare on each ack.
  int         stall_cnt, en_cnt, sel_cnt, en_busy;
  logic [7:0] en_addr;
  logic       en_we;
  always @(negedge clk) begin
    if (!reset) begin
      stall_cnt = 0; en_cnt = 0; sel_cnt = 0; en_busy = 0;
    end else begin
      if (cpu_stall) stall_cnt++;
      if (mem_sel)   sel_cnt++;
      if (mem_en) begin
        en_cnt++;
        en_addr = mem_addr;
        en_we   = mem_we;
        if (cpu_mem_busy) en_busy++;
      end
      if (dbg_ack) begin
        acks++;
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", 32'(dbg_ack), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("ack_cycle", cyc, e.ack_cyc);
          chk("dbg_err", 32'(dbg_err), 32'(e.err));
          chk("dbg_rdata", dbg_rdata, e.rdata);
          chk("stall_cycles", stall_cnt, e.stall);
          chk("mem_en_pulses", en_cnt, e.en);
          chk("mem_sel_cycles", sel_cnt, e.sel);
          chk("en_while_busy", en_busy, 0);
          if (e.en > 0) begin
            chk("mem_addr", 32'(en_addr), 32'(e.addr));
            chk("mem_we", 32'(en_we), 32'(e.we));
          end
        end
        stall_cnt = 0; en_cnt = 0; sel_cnt = 0; en_busy = 0;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Issue one request; expected latency/side effects follow from we/err/busy.
  task automatic do_req(input logic we, input logic [7:0] addr, input logic [31:0] wd,
                        input logic exp_err, input logic [31:0] exp_rdata,
                        input int busy_cyc, input int hold);
    exp_t e;
    int   a0;
    e.err     = exp_err;
    e.rdata   = exp_rdata;
    e.we      = we;
    e.addr    = addr;
    e.ack_cyc = cyc + (exp_err ? 1 : (we ? 3 : 4) + busy_cyc);
    e.stall   = exp_err ? 0 : (we ? 2 : 3) + busy_cyc;
    e.en      = exp_err ? 0 : 1;
    e.sel     = exp_err ? 0 : (we ? 1 : 2);
    dbg_we = we; dbg_addr = addr; dbg_wdata = wd; dbg_req = 1'b1;
    cpu_mem_busy = (busy_cyc > 0);
    exp_q.push_back(e);
    a0 = acks;
    for (int i = 1; i <= 40 && acks == a0; i++) begin
      step();
      if (i == busy_cyc + 1) cpu_mem_busy = 1'b0;
      if (i == 1) begin
        dbg_we = ~we; dbg_addr = 8'hC8; dbg_wdata = ~wd;
      end
    end
    if (acks == a0) begin
      chk("ack_timeout", 32'(acks), 32'(a0 + 1));
      exp_q.delete();
    end
    repeat (hold) step();
    chk("single_ack", 32'(acks), 32'(a0 + 1));
    dbg_req = 1'b0;
    cpu_mem_busy = 1'b0;
    step();
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    reset = 1'b0; dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    cpu_mem_busy = 1'b0;
    repeat (3) step();
    chk("rst_ack", 32'(dbg_ack), 32'd0);
    chk("rst_err", 32'(dbg_err), 32'd0);
    chk("rst_rdata", dbg_rdata, 32'd0);
    chk("rst_stall", 32'(cpu_stall), 32'd0);
    chk("rst_mem_ctrl", 32'({mem_sel, mem_en, mem_we}), 32'd0);
    chk("rst_mem_bus", 32'(mem_addr) | mem_wdata, 32'd0);
    reset = 1'b1;
    step();

    // write 8=6 then read it back
    do_req(1'b1, 8'd8, 32'd6, 1'b0, 32'd0, 0, 0);
    do_req(1'b0, 8'd8, 32'd0, 1'b0, 32'd6, 0, 0);
    // out-of-range read and write: err, no access, rdata kept
    do_req(1'b0, 8'd64, 32'd0, 1'b1, 32'd6, 0, 0);
    do_req(1'b1, 8'd200, 32'h0BAD_0BAD, 1'b1, 32'd6, 0, 0);
    // top valid address
    do_req(1'b0, 8'd63, 32'd0, 1'b0, 32'h0000_103F, 0, 0);
    do_req(1'b1, 8'd63, 32'hCAFE_F00D, 1'b0, 32'h0000_103F, 0, 0);
    do_req(1'b0, 8'd63, 32'd0, 1'b0, 32'hCAFE_F00D, 0, 0);
    // CPU memory busy for 3 cycles
    do_req(1'b0, 8'd8, 32'd0, 1'b0, 32'd6, 3, 0);
    // req held 10 cycles past ack, then a fresh request
    do_req(1'b1, 8'd10, 32'h0000_0077, 1'b0, 32'd6, 0, 10);
    do_req(1'b0, 8'd10, 32'd0, 1'b0, 32'h0000_0077, 0, 0);
    do_req(1'b0, 8'd200, 32'd0, 1'b1, 32'h0000_0077, 0, 0);

    // Reset while a write sits in STALL
    a0 = acks;
    dbg_we = 1'b1; dbg_addr = 8'd9; dbg_wdata = 32'hDEAD_BEEF; dbg_req = 1'b1;
    cpu_mem_busy = 1'b1;
    step();
    step();
    step();
    reset = 1'b0;
    #1;
    chk("mid_rst_stall", 32'(cpu_stall), 32'd0);
    chk("mid_rst_mem_en", 32'(mem_en), 32'd0);
    chk("mid_rst_ack", 32'(dbg_ack), 32'd0);
    step();
    // Release reset with a read already requested: accepted at once.
    cpu_mem_busy = 1'b0;
    begin
      exp_t e;
      e.err = 1'b0; e.rdata = 32'h0000_1009; e.ack_cyc = cyc + 4;
      e.stall = 3; e.en = 1; e.sel = 2; e.we = 1'b0; e.addr = 8'd9;
      exp_q.push_back(e);
    end
    dbg_we = 1'b0; dbg_addr = 8'd9; dbg_wdata = 32'd0; dbg_req = 1'b1;
    reset = 1'b1;
    for (int i = 0; i < 40 && acks == a0; i++) step();
    chk("post_rst_ack_count", 32'(acks), 32'(a0 + 1));
    dbg_req = 1'b0;
    step();
    step();

    repeat (3) step();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
